// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous 8-bit memory.
// Requests are granted combinationally; responses return two cycles after the transfer edge.
module mem_arbiter #(
    parameter int addrBusWidth = 13,
    parameter int roundRobin   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [addrBusWidth-1:0] addr0,
    input  logic [7:0]              wdata0,
    input  logic                    lock0,
    output logic                    ack0,
    output logic                    rvalid0,
    output logic [7:0]              rdata0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [addrBusWidth-1:0] addr1,
    input  logic [7:0]              wdata1,
    input  logic                    lock1,
    output logic                    ack1,
    output logic                    rvalid1,
    output logic [7:0]              rdata1,
    output logic [addrBusWidth-1:0] mem_addr,
    output logic [7:0]              mem_dataIn,
    output logic                    mem_write,
    output logic                    mem_strobe,
    input  logic [7:0]              mem_dataOut
);

    logic                    r_lastServed;
    logic                    r_lockValid;
    logic                    r_lockOwner;
    logic [addrBusWidth-1:0] r_memAddr;
    logic [7:0]              r_memDataIn;
    logic                    r_memWrite;
    logic                    r_memStrobe;
    logic                    r_issueTag;
    logic                    r_respValid;
    logic                    r_respTag;

    logic                    w_ack0;
    logic                    w_ack1;
    logic                    w_xfer;
    logic                    w_sel;
    logic [addrBusWidth-1:0] w_selAddr;
    logic [7:0]              w_selData;
    logic                    w_selWe;
    logic                    w_selLock;

    // A held lock shuts the other port out entirely, even while the owner is idle.
    always_comb begin
        w_ack0 = 1'b0;
        w_ack1 = 1'b0;
        if (r_lockValid) begin
            w_ack0 = req0 & ~r_lockOwner;
            w_ack1 = req1 & r_lockOwner;
        end else if (req0 && req1) begin
            if ((roundRobin != 0) && !r_lastServed) begin
                w_ack1 = 1'b1;
            end else begin
                w_ack0 = 1'b1;
            end
        end else begin
            w_ack0 = req0;
            w_ack1 = req1;
        end
    end

    assign w_xfer    = w_ack0 | w_ack1;
    assign w_sel     = w_ack1;
    assign w_selAddr = w_sel ? addr1  : addr0;
    assign w_selData = w_sel ? wdata1 : wdata0;
    assign w_selWe   = w_sel ? we1    : we0;
    assign w_selLock = w_sel ? lock1  : lock0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastServed <= 1'b1;
            r_lockValid  <= 1'b0;
            r_lockOwner  <= 1'b0;
        end else if (w_xfer) begin
            r_lastServed <= w_sel;
            r_lockValid  <= w_selLock;
            r_lockOwner  <= w_sel;
        end
    end

    // Address and data hold through idle cycles so the memory bus stays quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memAddr   <= '0;
            r_memDataIn <= '0;
            r_memWrite  <= 1'b0;
            r_memStrobe <= 1'b0;
            r_issueTag  <= 1'b0;
        end else begin
            r_memStrobe <= w_xfer;
            if (w_xfer) begin
                r_memAddr   <= w_selAddr;
                r_memDataIn <= w_selData;
                r_memWrite  <= w_selWe;
                r_issueTag  <= w_sel;
            end else begin
                r_memWrite  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_respValid <= 1'b0;
            r_respTag   <= 1'b0;
        end else begin
            r_respValid <= r_memStrobe;
            r_respTag   <= r_issueTag;
        end
    end

    assign ack0       = w_ack0;
    assign ack1       = w_ack1;
    assign mem_addr   = r_memAddr;
    assign mem_dataIn = r_memDataIn;
    assign mem_write  = r_memWrite;
    assign mem_strobe = r_memStrobe;
    assign rvalid0    = r_respValid & ~r_respTag;
    assign rvalid1    = r_respValid & r_respTag;
    assign rdata0     = mem_dataOut;
    assign rdata1     = mem_dataOut;

endmodule
